// File: rtl/aes_pkg.sv
// Shared AES core definitions: opcode encoding seen by aes_ctrl and its requesters.
// Pure type package, no logic.
package aes_pkg;

    typedef enum logic [3:0] {
        NOOP            = 4'd0,
        AESENC          = 4'd1,
        AESENCLAST      = 4'd2,
        AESDEC          = 4'd3,
        AESDECLAST      = 4'd4,
        AESKEYGENASSIST = 4'd5,
        AESIMC          = 4'd6,
        AESENCFULL      = 4'd7,
        AESDECFULL      = 4'd8
    } opcode;

endpackage

// File: rtl/aes_req_arb_if.sv
// Requester and core-control bundle of aes_req_arb; slave is the arbiter view,
// master is the requester/core side. No storage, no flow control of its own.
interface aes_req_arb_if #(
    parameter int N_REQ = 2
);

    logic [N_REQ-1:0] req_i;
    aes_pkg::opcode   opcode_i [N_REQ];
    logic [N_REQ-1:0] gnt_o;
    logic [N_REQ-1:0] done_o;
    logic             err_o;
    logic             busy_o;
    logic             core_start_o;
    aes_pkg::opcode   core_opcode_o;
    logic             core_cipher_ready_i;
    logic             core_key_ready_i;

    modport slave (
        input  req_i, opcode_i, core_cipher_ready_i, core_key_ready_i,
        output gnt_o, done_o, err_o, busy_o, core_start_o, core_opcode_o
    );

    modport master (
        output req_i, opcode_i, core_cipher_ready_i, core_key_ready_i,
        input  gnt_o, done_o, err_o, busy_o, core_start_o, core_opcode_o
    );

endinterface

// File: rtl/aes_req_arb.sv
// Round-robin sharing of one AES core; optional WAIT watchdog under AES_ARB_TIMEOUT_EN.
// Grant/start 1 cycle after request, done 2 cycles after core ready; requests stay pending while busy.
module aes_req_arb #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input logic          clk,
    input logic          nrst,
    aes_req_arb_if.slave bus
);
    import aes_pkg::*;

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    opcode         op_q, op_d;
    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand_idx;
    int            cand;
    logic          exp_rdy;
    logic          hit_q;
    logic          tmo_q;
    logic [N_REQ-1:0] gnt, done;
    logic          start;
    opcode         core_op;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = IW'(cand);
            if (bus.req_i[cand_idx] && (bus.opcode_i[cand_idx] != NOOP)) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    assign exp_rdy = (op_q == AESKEYGENASSIST) ? bus.core_key_ready_i : bus.core_cipher_ready_i;

    // Core ready is registered before use, giving the done-after-ready latency of two cycles.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) hit_q <= 1'b0;
        else       hit_q <= (state_q == WAIT) && exp_rdy;
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYC - 1));
            if (state_q == DONE)      cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + CW'(1);
            // A ready sampled alongside the expiry takes precedence.
            if (state_q == WAIT)      err_q <= tmo_q && !hit_q;
        end
    end

    assign bus.err_o = (state_q == DONE) && err_q;
`else
    logic unused_timeout;

    assign tmo_q          = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign bus.err_o      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    idx_d   = win_idx;
                    op_d    = bus.opcode_i[win_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (hit_q || tmo_q) state_d = DONE;
            end
            DONE: begin
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            op_q    <= NOOP;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        gnt     = '0;
        done    = '0;
        start   = 1'b0;
        core_op = NOOP;
        case (state_q)
            ISSUE: begin
                gnt[idx_q] = 1'b1;
                start      = 1'b1;
                core_op    = op_q;
            end
            DONE:    done[idx_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.gnt_o         = gnt;
    assign bus.done_o        = done;
    assign bus.core_start_o  = start;
    assign bus.core_opcode_o = core_op;
    assign bus.busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_aes_req_arb.sv
// Bench for aes_req_arb: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and grant orders.
module tb_aes_req_arb;
    import aes_pkg::*;

    localparam int N  = 2;
    localparam int TO = 8;
`ifdef AES_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 1'b0;

    aes_req_arb_if #(.N_REQ(N)) bus ();

    aes_req_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] e_gnt, e_done;
    logic         e_err, e_busy, e_start;
    opcode        e_op;
    int           m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_exp(input logic [N-1:0] g, input logic [N-1:0] d, input logic er,
                           input logic bs, input logic st, input opcode op);
        e_gnt = g; e_done = d; e_err = er; e_busy = bs; e_start = st; e_op = op;
    endtask

    task automatic set_idle();
        set_exp('0, '0, 1'b0, 1'b0, 1'b0, NOOP);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick();
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (bus.req_i[k] && bus.opcode_i[k] != NOOP) return k;
        end
        return -1;
    endfunction

    function automatic logic rdy_match(input opcode op);
        return (op == AESKEYGENASSIST) ? bus.core_key_ready_i : bus.core_cipher_ready_i;
    endfunction

    // One clock of the model; reports whether reset was seen instead.
    task automatic step(output bit rst);
        @(posedge clk or negedge nrst);
        rst = (nrst == 1'b0);
    endtask

    // Transaction view: pick a winner, issue, wait for its ready (or the watchdog),
    // one sampling cycle, done, then rotate past the winner.
    initial begin : model
        bit    r;
        int    idx;
        int    w;
        bit    fin;
        bit    ferr;
        opcode op;
        m_ptr = 0;
        set_idle();
        forever begin
            step(r);
            if (r) begin
                m_ptr = 0;
                set_idle();
            end else begin
                idx = pick();
                if (idx >= 0) begin
                    op = bus.opcode_i[idx];
                    set_exp(onehot(idx), '0, 1'b0, 1'b1, 1'b1, op);
                    step(r);
                    fin = 1'b0; ferr = 1'b0; w = 0;
                    if (!r) set_exp('0, '0, 1'b0, 1'b1, 1'b0, NOOP);
                    while (!r && !fin) begin
                        step(r);
                        if (!r) begin
                            w++;
                            if (rdy_match(op)) fin = 1'b1;
                            else if (TMO_ON && w == TO) begin fin = 1'b1; ferr = 1'b1; end
                        end
                    end
                    if (!r) step(r);
                    if (!r) begin
                        set_exp('0, onehot(idx), ferr, 1'b1, 1'b0, NOOP);
                        step(r);
                    end
                    m_ptr = r ? 0 : (idx + 1) % N;
                    set_idle();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            chk("cycle outputs {gnt,done,err,busy,start,op}",
                {bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.core_start_o, bus.core_opcode_o},
                {e_gnt, e_done, e_err, e_busy, e_start, e_op});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the ISSUE cycle; pulses one ready and returns in the DONE cycle.
    task automatic finish_op(input bit use_key, output logic [N-1:0] d, output logic e);
        int n;
        tick();
        if (use_key) bus.core_key_ready_i = 1'b1; else bus.core_cipher_ready_i = 1'b1;
        tick();
        bus.core_key_ready_i = 1'b0; bus.core_cipher_ready_i = 1'b0;
        n = 0;
        while (bus.done_o == '0 && n < 20) begin tick(); n++; end
        chk("done arrives within bound", (n < 20), 1);
        d = bus.done_o;
        e = bus.err_o;
        tick();
    endtask

    task automatic wait_gnt(output logic [N-1:0] g);
        int n;
        n = 0;
        while (bus.gnt_o == '0 && n < 20) begin tick(); n++; end
        chk("grant arrives within bound", (n < 20), 1);
        g = bus.gnt_o;
    endtask

    initial begin : stim
        logic [N-1:0] g, d;
        logic         e;
        logic [N-1:0] seq [4];
        int           n, ng, nd;
        nrst = 1'b0;
        bus.req_i = '0;
        bus.opcode_i[0] = NOOP;
        bus.opcode_i[1] = NOOP;
        bus.core_cipher_ready_i = 1'b0;
        bus.core_key_ready_i    = 1'b0;
        tick(); tick();
        cmp_en = 1'b1;
        tick();
        chk("reset gnt/done/err/busy/start", {bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.core_start_o}, 0);
        chk("reset core_opcode", bus.core_opcode_o, NOOP);
        nrst = 1'b1;
        tick();

        // Single AESENC from requester 0, cipher ready 3 cycles after start.
        bus.req_i[0] = 1'b1; bus.opcode_i[0] = AESENC;
        tick();
        chk("single gnt", bus.gnt_o, 2'b01);
        chk("single start", bus.core_start_o, 1);
        chk("single opcode", bus.core_opcode_o, AESENC);
        bus.req_i[0] = 1'b0; bus.opcode_i[0] = NOOP;
        tick(); tick(); tick();
        bus.core_cipher_ready_i = 1'b1;
        tick();
        bus.core_cipher_ready_i = 1'b0;
        chk("single no early done", bus.done_o, 2'b00);
        tick();
        chk("single done 2 after ready", bus.done_o, 2'b01);
        chk("single err", bus.err_o, 0);
        tick();

        // Reset in WAIT: pointer was 1, after reset both requesting -> requester 0.
        bus.req_i = 2'b11; bus.opcode_i[0] = AESENC; bus.opcode_i[1] = AESDEC;
        tick();
        chk("rr gnt to 1", bus.gnt_o, 2'b10);
        tick(); tick();
        nrst = 1'b0;
        #1;
        chk("mid-wait reset outputs", {bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.core_start_o}, 0);
        tick();
        chk("aborted op no done", bus.done_o, 2'b00);
        nrst = 1'b1;
        tick();
        chk("post-reset gnt to 0", bus.gnt_o, 2'b01);

        // Fairness with both requests held.
        seq[0] = bus.gnt_o;
        for (int i = 1; i < 4; i++) begin
            finish_op(1'b0, d, e);
            wait_gnt(g);
            seq[i] = g;
        end
        bus.req_i = '0; bus.opcode_i[0] = NOOP; bus.opcode_i[1] = NOOP;
        finish_op(1'b0, d, e);
        chk("fair grant 0", seq[0], 2'b01);
        chk("fair grant 1", seq[1], 2'b10);
        chk("fair grant 2", seq[2], 2'b01);
        chk("fair grant 3", seq[3], 2'b10);
        chk("fair last done", d, 2'b10);

        // Key-generation op only completes on key ready.
        bus.req_i[1] = 1'b1; bus.opcode_i[1] = AESKEYGENASSIST;
        tick();
        chk("keygen gnt", bus.gnt_o, 2'b10);
        bus.req_i[1] = 1'b0; bus.opcode_i[1] = NOOP;
        tick();
        bus.core_cipher_ready_i = 1'b1;
        tick();
        bus.core_cipher_ready_i = 1'b0;
        tick(); tick();
        chk("cipher ready ignored done", bus.done_o, 2'b00);
        chk("cipher ready ignored busy", bus.busy_o, 1);
        bus.core_key_ready_i = 1'b1;
        tick();
        bus.core_key_ready_i = 1'b0;
        tick();
        chk("keygen done", bus.done_o, 2'b10);
        tick();

        // NOOP requester never granted; a request withdrawn before grant is lost.
        bus.req_i = 2'b11; bus.opcode_i[0] = NOOP; bus.opcode_i[1] = AESENCFULL;
        tick();
        chk("noop filter gnt", bus.gnt_o, 2'b10);
        bus.req_i[1] = 1'b0; bus.opcode_i[1] = NOOP;
        tick();
        bus.opcode_i[0] = AESENC;
        tick();
        bus.opcode_i[0] = NOOP;
        bus.core_cipher_ready_i = 1'b1;
        tick();
        bus.core_cipher_ready_i = 1'b0;
        ng = 0; nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.gnt_o != '0) ng++;
            if (bus.done_o == 2'b10) nd++;
            tick();
        end
        chk("noop/withdrawn never granted", ng, 0);
        chk("noop filter one done", nd, 1);
        bus.req_i = '0;
        tick();

`ifdef AES_ARB_TIMEOUT_EN
        bus.req_i[0] = 1'b1; bus.opcode_i[0] = AESENC;
        tick();
        bus.req_i[0] = 1'b0; bus.opcode_i[0] = NOOP;
        n = 0;
        while (bus.done_o == '0 && n < 30) begin tick(); n++; end
        chk("timeout done cycle after start", n, 10);
        chk("timeout done", bus.done_o, 2'b01);
        chk("timeout err", bus.err_o, 1);
        tick();
        bus.req_i[0] = 1'b1; bus.opcode_i[0] = AESENC;
        tick();
        bus.req_i[0] = 1'b0; bus.opcode_i[0] = NOOP;
        repeat (8) tick();
        bus.core_cipher_ready_i = 1'b1;
        tick();
        bus.core_cipher_ready_i = 1'b0;
        tick();
        chk("ready at expiry done", bus.done_o, 2'b01);
        chk("ready at expiry no err", bus.err_o, 0);
        tick();
`else
        bus.req_i[0] = 1'b1; bus.opcode_i[0] = AESENC;
        tick();
        bus.req_i[0] = 1'b0; bus.opcode_i[0] = NOOP;
        repeat (30) tick();
        chk("no watchdog still waiting", {bus.busy_o, bus.done_o}, 3'b100);
        bus.core_cipher_ready_i = 1'b1;
        tick();
        bus.core_cipher_ready_i = 1'b0;
        tick();
        chk("late ready done", bus.done_o, 2'b01);
        chk("late ready err", bus.err_o, 0);
        tick();
`endif
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
